// File: rtl/wb_bram_bist.sv
// Built-in self-test sequencer for one Wishbone pipelined BRAM port.
// Runs four passes over the whole array: pattern write, pattern verify,
// inverse write, inverse verify. It keeps one request outstanding at a time
// and reports pass/fail, the first failing address/data and ack timeouts.
module wb_bram_bist #(
  parameter int          AW      = 4,
  parameter int          DW      = 8,
  parameter logic [31:0] SEED    = 32'h0000_00A5,
  parameter int          TIMEOUT = 15
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic          o_timeout,
  output logic [AW-1:0] o_fail_addr,
  output logic [DW-1:0] o_fail_data,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic [DW-1:0] i_wb_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_WRI  = 3'd3,
    S_RDI  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [7:0]    TO_LIM    = 8'(TIMEOUT);
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  // Test pattern: seed xor address, address resized to the data width.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [DW-1:0] ax;
    ax = DW'(a);
    return DW'(SEED) ^ ax;
  endfunction

  // Write data driven for a given pass; read passes drive zero.
  function automatic logic [DW-1:0] wdata_for(input state_t s, input logic [AW-1:0] a);
    case (s)
      S_WR:    return pat(a);
      S_WRI:   return ~pat(a);
      default: return {DW{1'b0}};
    endcase
  endfunction

  // Pass that follows the given one once its last address is done.
  function automatic state_t next_pass(input state_t s);
    case (s)
      S_WR:    return S_RD;
      S_RD:    return S_WRI;
      S_WRI:   return S_RDI;
      default: return S_DONE;
    endcase
  endfunction

  state_t        state_r, state_s, iss_state_s;
  logic          pend_r, pend_s;           // one request accepted, ack pending
  logic [7:0]    cnt_r, cnt_s;             // cycles since acceptance
  logic [AW-1:0] addr_r, addr_s, iss_addr_s;
  logic          cyc_r, cyc_s, stb_r, stb_s, we_r, we_s;
  logic [DW-1:0] wdata_r, wdata_s, exp_s;
  logic          busy_r, busy_s, done_r, done_s, pass_r, pass_s, tout_r, tout_s;
  logic [AW-1:0] faddr_r, faddr_s;
  logic [DW-1:0] fdata_r, fdata_s;
  logic          is_read_s;

  // Next-state and next-output logic for the test sequencer.
  always_comb begin
    state_s = state_r;  pend_s  = pend_r;  cnt_s   = cnt_r;   addr_s  = addr_r;
    cyc_s   = cyc_r;    stb_s   = stb_r;   we_s    = we_r;    wdata_s = wdata_r;
    busy_s  = busy_r;   done_s  = done_r;  pass_s  = pass_r;  tout_s  = tout_r;
    faddr_s = faddr_r;  fdata_s = fdata_r;
    is_read_s   = (state_r == S_RD) || (state_r == S_RDI);
    exp_s       = (state_r == S_RDI) ? ~pat(addr_r) : pat(addr_r);
    iss_state_s = (addr_r == LAST_ADDR) ? next_pass(state_r) : state_r;
    iss_addr_s  = addr_r + ADDR_ONE;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_s = S_WR;  pend_s = 1'b0;  cnt_s = 8'd0;  addr_s = {AW{1'b0}};
          cyc_s = 1'b1;  stb_s = 1'b1;  we_s = 1'b1;  wdata_s = pat({AW{1'b0}});
          busy_s = 1'b1;  done_s = 1'b0;  pass_s = 1'b0;  tout_s = 1'b0;
          faddr_s = {AW{1'b0}};  fdata_s = {DW{1'b0}};
        end else begin
          state_s = state_r;
        end
      end
      S_WR, S_RD, S_WRI, S_RDI: begin
        if (!pend_r) begin
          // Request phase: hold everything stable until the slave accepts.
          if (!i_wb_stall) begin
            pend_s = 1'b1;  stb_s = 1'b0;  cnt_s = 8'd1;
          end else begin
            stb_s = 1'b1;
          end
        end else if (i_wb_ack) begin
          if (is_read_s && (i_wb_data != exp_s)) begin
            state_s = S_DONE;  pend_s = 1'b0;  cyc_s = 1'b0;  stb_s = 1'b0;  we_s = 1'b0;
            busy_s = 1'b0;  done_s = 1'b1;  pass_s = 1'b0;
            faddr_s = addr_r;  fdata_s = i_wb_data;
          end else if (iss_state_s == S_DONE) begin
            state_s = S_DONE;  pend_s = 1'b0;  cyc_s = 1'b0;  stb_s = 1'b0;  we_s = 1'b0;
            addr_s = {AW{1'b0}};  wdata_s = {DW{1'b0}};
            busy_s = 1'b0;  done_s = 1'b1;  pass_s = 1'b1;
          end else begin
            // Issue the next word; cyc stays high across pass boundaries.
            state_s = iss_state_s;  pend_s = 1'b0;  stb_s = 1'b1;  addr_s = iss_addr_s;
            we_s = (iss_state_s == S_WR) || (iss_state_s == S_WRI);
            wdata_s = wdata_for(iss_state_s, iss_addr_s);
          end
        end else if (cnt_r >= TO_LIM) begin
          state_s = S_DONE;  pend_s = 1'b0;  cyc_s = 1'b0;  stb_s = 1'b0;  we_s = 1'b0;
          busy_s = 1'b0;  done_s = 1'b1;  pass_s = 1'b0;  tout_s = 1'b1;
          faddr_s = addr_r;  fdata_s = {DW{1'b0}};
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = S_IDLE;  pend_s = 1'b0;  cyc_s = 1'b0;  stb_s = 1'b0;  we_s = 1'b0;
        busy_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r <= S_IDLE;  pend_r <= 1'b0;  cnt_r <= 8'd0;  addr_r <= {AW{1'b0}};
      cyc_r <= 1'b0;  stb_r <= 1'b0;  we_r <= 1'b0;  wdata_r <= {DW{1'b0}};
      busy_r <= 1'b0;  done_r <= 1'b0;  pass_r <= 1'b0;  tout_r <= 1'b0;
      faddr_r <= {AW{1'b0}};  fdata_r <= {DW{1'b0}};
    end else begin
      state_r <= state_s;  pend_r <= pend_s;  cnt_r <= cnt_s;  addr_r <= addr_s;
      cyc_r <= cyc_s;  stb_r <= stb_s;  we_r <= we_s;  wdata_r <= wdata_s;
      busy_r <= busy_s;  done_r <= done_s;  pass_r <= pass_s;  tout_r <= tout_s;
      faddr_r <= faddr_s;  fdata_r <= fdata_s;
    end
  end

  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_pass      = pass_r;
  assign o_timeout   = tout_r;
  assign o_fail_addr = faddr_r;
  assign o_fail_data = fdata_r;
  assign o_wb_cyc    = cyc_r;
  assign o_wb_stb    = stb_r;
  assign o_wb_we     = we_r;
  assign o_wb_addr   = addr_r;
  assign o_wb_data   = wdata_r;

endmodule

// File: tb/tb_wb_bram_bist.sv
// Directed bench for wb_bram_bist with a behavioural BRAM slave that can
// corrupt one read, delay or drop one ack, and stall at random.
module tb_wb_bram_bist;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic       busy, done, pass, tout, cyc, stb, we;
  logic [3:0] faddr, addr;
  logic [7:0] fdata, wdata;

  wb_bram_bist dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(tout),
    .o_fail_addr(faddr), .o_fail_data(fdata),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_addr(addr), .o_wb_data(wdata),
    .i_wb_stall(stall), .i_wb_ack(ack), .i_wb_data(rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;

  // Slave state and fault-injection knobs.
  logic [7:0] mem [16];
  int   txn, pcnt, pidx, bad_txn, slow_txn, slow_dly, acc_cyc, stall_cnt, stab_err;
  bit   pend, pdrop, stall_en, st_prev;
  logic [3:0] paddr, st_addr;
  logic [7:0] bad_val, st_data;
  logic       st_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_slave();
    bad_txn = -1;  slow_txn = -1;  slow_dly = 1;  stall_en = 1'b0;
    txn = 0;  stall_cnt = 0;  stab_err = 0;  acc_cyc = 0;
  endtask

  task automatic do_start(output int t);
    t = cyc_n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    dc = cyc_n;
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // Slave: decide stall/ack/data at the falling edge for the next rising edge.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    pend = 1'b0;  pdrop = 1'b0;  st_prev = 1'b0;  pcnt = 0;  pidx = 0;
    paddr = 4'h0;  st_addr = 4'h0;  st_data = 8'h00;  st_we = 1'b0;  bad_val = 8'h00;
    reset_slave();
    forever begin
      @(negedge clk);
      ack = 1'b0;
      rdata = 8'h00;
      stall = 1'b0;
      if (!rst_n || !cyc) begin
        pend = 1'b0;
        st_prev = 1'b0;
      end else begin
        if (pend && !pdrop) begin
          pcnt--;
          if (pcnt == 0) begin
            ack = 1'b1;
            rdata = (pidx == bad_txn) ? bad_val : mem[paddr];
            pend = 1'b0;
          end
        end
        if (stb) begin
          if (st_prev && (addr !== st_addr || wdata !== st_data || we !== st_we)) stab_err++;
          if (stall_en && ($urandom_range(1, 0) == 1)) begin
            stall = 1'b1;
            stall_cnt++;
            st_prev = 1'b1;
            st_addr = addr;  st_data = wdata;  st_we = we;
          end else begin
            st_prev = 1'b0;
            if (we) mem[addr] = wdata;
            pend = 1'b1;
            paddr = addr;
            pidx = txn;
            pdrop = (txn == slow_txn) && (slow_dly == 0);
            pcnt = (txn == slow_txn) ? slow_dly : 1;
            if (txn == slow_txn) acc_cyc = cyc_n;
            txn++;
          end
        end else begin
          st_prev = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, dc, n;
    repeat (3) @(negedge clk);
    chk("rst_flags", {25'd0, busy, done, pass, tout, cyc, stb, we}, 32'd0);
    chk("rst_addr", {24'd0, faddr, addr}, 32'd0);
    chk("rst_data", {16'd0, fdata, wdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ideal slave, full pass
    reset_slave();
    do_start(t);
    chk("t1_first_req", {24'd0, busy, cyc, stb, we, addr}, {24'd0, 4'b1111, 4'h0});
    chk("t1_first_data", {24'd0, wdata}, 32'h0000_00A5);
    @(negedge clk);
    chk("t1_stb_low", {30'd0, cyc, stb}, 32'd2);
    @(negedge clk);
    chk("t1_second_req", {20'd0, stb, addr, wdata}, {20'd0, 1'b1, 4'h1, 8'hA4});
    wait_done(400, dc);
    chk("t1_latency", dc - t, 32'd129);
    chk("t1_result", {28'd0, busy, pass, tout, cyc}, 32'd4);
    chk("t1_mem7", {24'd0, mem[7]}, 32'h0000_005D);
    chk("t1_mem0", {24'd0, mem[0]}, 32'h0000_005A);

    // 2: corrupt the RD read of address 3
    reset_slave();
    bad_txn = 19;  bad_val = 8'h00;
    do_start(t);
    chk("t2_cleared", {30'd0, done, pass}, 32'd0);
    wait_done(400, dc);
    chk("t2_latency", dc - t, 32'd41);
    chk("t2_result", {29'd0, pass, tout, cyc}, 32'd0);
    chk("t2_fail_addr", {28'd0, faddr}, 32'd3);
    chk("t2_fail_data", {24'd0, fdata}, 32'd0);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (stb) n++;
    end
    chk("t2_no_more_stb", n, 32'd0);

    // 3a: RDI read at address 3 returns its correct value 8'h59
    reset_slave();
    bad_txn = 51;  bad_val = 8'h59;
    do_start(t);
    chk("t3a_cleared", {20'd0, faddr, fdata}, 32'd0);
    wait_done(400, dc);
    chk("t3a_latency", dc - t, 32'd129);
    chk("t3a_pass", {31'd0, pass}, 32'd1);

    // 3b: RDI read at address 3 returns the uninverted pattern
    reset_slave();
    bad_txn = 51;  bad_val = 8'hA6;
    do_start(t);
    wait_done(400, dc);
    chk("t3b_latency", dc - t, 32'd105);
    chk("t3b_fail", {19'd0, pass, tout, faddr, fdata}, {19'd0, 2'b00, 4'h3, 8'hA6});

    // 4: random 50% stall
    reset_slave();
    stall_en = 1'b1;
    do_start(t);
    wait_done(1500, dc);
    chk("t4_pass", {31'd0, pass}, 32'd1);
    chk("t4_latency", dc - t, 129 + stall_cnt);
    chk("t4_stable", stab_err, 32'd0);
    chk("t4_stalled_some", {31'd0, (stall_cnt > 0)}, 32'd1);

    // 5a: no ack for the WR of address 5
    reset_slave();
    slow_txn = 5;  slow_dly = 0;
    do_start(t);
    wait_done(400, dc);
    chk("t5a_accept_cycle", acc_cyc - t, 32'd11);
    chk("t5a_latency", dc - acc_cyc, 32'd16);
    chk("t5a_result", {28'd0, pass, tout, cyc, busy}, 32'd4);
    chk("t5a_fail", {20'd0, faddr, fdata}, {20'd0, 4'h5, 8'h00});

    // 5b: ack for address 5 arrives on the 15th cycle after acceptance
    reset_slave();
    slow_txn = 5;  slow_dly = 15;
    do_start(t);
    wait_done(400, dc);
    chk("t5b_latency", dc - t, 32'd143);
    chk("t5b_result", {30'd0, pass, tout}, 32'd2);

    // 6: reset in the middle of RD, then start pulsed while busy
    reset_slave();
    do_start(t);
    n = 0;
    while (txn < 20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_rd", {31'd0, (txn >= 20)}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_flags", {25'd0, busy, done, pass, tout, cyc, stb, we}, 32'd0);
    chk("t6_rst_vals", {12'd0, faddr, fdata, addr, wdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    reset_slave();
    do_start(t);
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_start_ignored", {27'd0, stb, addr}, {27'd0, 1'b1, 4'h5});
    wait_done(400, dc);
    chk("t6_latency", dc - t, 32'd129);
    chk("t6_pass", {31'd0, pass}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
